id_ex_stage: RTL and testbench

- Decode/issue pipeline register directly downstream of register_file.
- Takes the fetched instruction and PC, and slices out rs1/rs2/rd. The rs1/rs2 indices drive the register_file read ports.
- Captures read_data_1/2 with same-cycle writeback bypass, generates the immediate and basic control, and presents a registered bundle to the execute stage.
- Uses a valid/ready handshake and detects load-use hazards.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/imm_gen.sv | 44 ++++
 rtl/id_ex_stage.sv | 136 +++++++++++++
 tb/tb_id_ex_stage.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 decode definitions: opcode constants, datapath widths and the
// immediate-format enum used by the decode/issue stage and later pipeline stages.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

endpackage

// File: rtl/imm_gen.sv
// Combinational instruction-to-immediate decoder: classifies the opcode into an
// immediate format and returns the sign-extended immediate (zero for no format).
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]           instr,
  output logic [XLEN-1:0]       imm,
  output riscv_pkg::imm_type_e  imm_type
);
  import riscv_pkg::*;

  logic [31:0] imm32;
  logic        unused_funct3;

  assign unused_funct3 = ^instr[14:12];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    imm_type = IMM_NONE;
    case (instr[6:0])
      OP_LOAD, OP_OPIMM, OP_JALR: imm_type = IMM_I;
      OP_STORE:                   imm_type = IMM_S;
      OP_BRANCH:                  imm_type = IMM_B;
      OP_LUI, OP_AUIPC:           imm_type = IMM_U;
      OP_JAL:                     imm_type = IMM_J;
      default:                    imm_type = IMM_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ex_stage.sv
// Decode/issue pipeline register between register_file and execute, with
// writeback bypass and valid/ready handshake. Define LOAD_USE_STALL_EN to add
// the load-use hazard stall; otherwise hazard is tied low.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_instr,
  input  logic [XLEN-1:0]   in_pc,
  output logic [REG_AW-1:0] rs1_addr,
  output logic [REG_AW-1:0] rs2_addr,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_val,
  output logic [XLEN-1:0]   out_rs2_val,
  output logic [XLEN-1:0]   out_imm,
  output logic [REG_AW-1:0] out_rd,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic              out_reg_write,
  output logic              out_mem_read,
  output logic              out_mem_write
);
  import riscv_pkg::*;

  logic [6:0]        opcode;
  logic [REG_AW-1:0] rd;
  logic [XLEN-1:0]   imm;
  imm_type_e         imm_kind;
  logic              unused_imm_kind;
  logic              dec_reg_write;
  logic              dec_mem_read;
  logic              dec_mem_write;
  logic              hazard;
  logic              accept;
  logic              wb_live;
  logic [REG_AW-1:0] cap_rs1;
  logic [REG_AW-1:0] cap_rs2;

  assign opcode          = in_instr[6:0];
  assign rd              = in_instr[11:7];
  assign rs1_addr        = in_instr[19:15];
  assign rs2_addr        = in_instr[24:20];
  assign unused_imm_kind = ^imm_kind;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr    (in_instr[31:0]),
    .imm      (imm),
    .imm_type (imm_kind)
  );

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    case (opcode)
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: dec_reg_write = 1'b1;
      OP_LOAD: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_STORE: dec_mem_write = 1'b1;
      default: ;
    endcase
    if (rd == '0) dec_reg_write = 1'b0;
  end

`ifdef LOAD_USE_STALL_EN
  // rs2 is compared even for opcodes that ignore it; the extra stall is harmless.
  assign hazard = out_valid && out_mem_read && (out_rd != '0) && in_valid &&
                  ((out_rd == rs1_addr) || (out_rd == rs2_addr));
`else
  assign hazard = 1'b0;
`endif

  assign in_ready = (!out_valid || out_ready) && !hazard;
  assign accept   = in_valid && in_ready && !flush;
  assign wb_live  = wb_we && (wb_rd != '0);

  // NOTE: reset is synchronous and sits first in the if-chain, giving rst > flush > accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_rs1_val   <= '0;
      out_rs2_val   <= '0;
      out_imm       <= '0;
      out_rd        <= '0;
      out_opcode    <= '0;
      out_funct3    <= '0;
      out_funct7    <= '0;
      out_reg_write <= 1'b0;
      out_mem_read  <= 1'b0;
      out_mem_write <= 1'b0;
      cap_rs1       <= '0;
      cap_rs2       <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      // register_file still returns the old value during its write cycle
      out_rs1_val   <= (wb_live && wb_rd == rs1_addr) ? wb_data : rs1_data;
      out_rs2_val   <= (wb_live && wb_rd == rs2_addr) ? wb_data : rs2_data;
      out_imm       <= imm;
      out_rd        <= rd;
      out_opcode    <= opcode;
      out_funct3    <= in_instr[14:12];
      out_funct7    <= in_instr[31:25];
      out_reg_write <= dec_reg_write;
      out_mem_read  <= dec_mem_read;
      out_mem_write <= dec_mem_write;
      cap_rs1       <= rs1_addr;
      cap_rs2       <= rs2_addr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid && wb_live) begin
      // A held bundle must still observe writebacks that retire while it waits.
      if (wb_rd == cap_rs1) out_rs1_val <= wb_data;
      if (wb_rd == cap_rs2) out_rs2_val <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a decode/bypass vector table plus hand-written
// backpressure, load-use, flush and reset sequences.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_ready;
  logic [31:0] in_instr, in_pc, rs1_data, rs2_data, wb_data;
  logic [4:0]  rs1_addr, rs2_addr, wb_rd;
  logic        wb_we;
  logic        out_valid, out_reg_write, out_mem_read, out_mem_write;
  logic [31:0] out_pc, out_rs1_val, out_rs2_val, out_imm;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;

  int checks   = 0;
  int failures = 0;

  id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_imm(out_imm),
    .out_rd(out_rd), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_reg_write(out_reg_write),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, r1, r2;
    logic        we;
    logic [4:0]  wrd;
    logic [31:0] wdata;
    logic [31:0] e_rs1, e_rs2, e_imm;
    logic [4:0]  e_rd;
    logic [6:0]  e_op;
    logic [2:0]  e_f3;
    logic [6:0]  e_f7;
    logic        e_rw, e_mr, e_mw;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; in_instr = instr; in_pc = pc; rs1_data = r1; rs2_data = r2;
  endtask

  task automatic wb(input logic we, input logic [4:0] rd, input logic [31:0] data);
    wb_we = we; wb_rd = rd; wb_data = data;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_pc"},    out_pc, 32'd0);
    check({tag, "_rs1"},   out_rs1_val, 32'd0);
    check({tag, "_rs2"},   out_rs2_val, 32'd0);
    check({tag, "_imm"},   out_imm, 32'd0);
    check({tag, "_rd"},    32'(out_rd), 32'd0);
    check({tag, "_op"},    32'(out_opcode), 32'd0);
    check({tag, "_f3f7"},  32'({out_funct3, out_funct7}), 32'd0);
    check({tag, "_ctl"},   32'({out_reg_write, out_mem_read, out_mem_write}), 32'd0);
  endtask

  initial begin
    //          instr         pc      r1            r2            we    wrd    wdata           e_rs1         e_rs2         e_imm         e_rd   e_op    e_f3  e_f7   rw    mr    mw
    vecs[0]  = '{32'hFFD00293, 32'h100, 32'h0,        32'h22222222, 1'b1, 5'd0,  32'hDEADBEEF, 32'h0,        32'h22222222, 32'hFFFFFFFD, 5'd5,  7'h13, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{32'h000380B3, 32'h104, 32'h0,        32'h0,        1'b1, 5'd7,  32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'h0,        5'd1,  7'h33, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{32'h000380B3, 32'h108, 32'h12345678, 32'h0,        1'b1, 5'd0,  32'hDEADBEEF, 32'h12345678, 32'h0,        32'h0,        5'd1,  7'h33, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{32'h00918533, 32'h10C, 32'h11111111, 32'h0,        1'b1, 5'd9,  32'hCAFEF00D, 32'h11111111, 32'hCAFEF00D, 32'h0,        5'd10, 7'h33, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'h00612423, 32'h110, 32'h1000,     32'hABCD,     1'b0, 5'd0,  32'h0,        32'h1000,     32'hABCD,     32'h8,        5'd8,  7'h23, 3'd2, 7'h00, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'hFE208EE3, 32'h114, 32'h5,        32'h6,        1'b0, 5'd0,  32'h0,        32'h5,        32'h6,        32'hFFFFFFFC, 5'd29, 7'h63, 3'd0, 7'h7F, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h12345437, 32'h118, 32'h10,       32'h20,       1'b1, 5'd3,  32'h77,       32'h10,       32'h77,       32'h12345000, 5'd8,  7'h37, 3'd5, 7'h09, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{32'h008000EF, 32'h11C, 32'h0,        32'h88,       1'b0, 5'd0,  32'h0,        32'h0,        32'h88,       32'h8,        5'd1,  7'h6F, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'hFFFFFFFF, 32'h120, 32'hA,        32'hB,        1'b0, 5'd0,  32'h0,        32'hA,        32'hB,        32'h0,        5'd31, 7'h7F, 3'd7, 7'h7F, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00000013, 32'h124, 32'h0,        32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        5'd0,  7'h13, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFF0280E7, 32'h128, 32'h40,       32'h50,       1'b0, 5'd0,  32'h0,        32'h40,       32'h50,       32'hFFFFFFF0, 5'd1,  7'h67, 3'd0, 7'h7F, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{32'h00012183, 32'h12C, 32'h2000,     32'h0,        1'b0, 5'd0,  32'h0,        32'h2000,     32'h0,        32'h0,        5'd3,  7'h03, 3'd2, 7'h00, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_all_zero("reset");
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);

    // Decode and bypass table, one instruction per cycle with execute always ready.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, vecs[i].instr, vecs[i].pc, vecs[i].r1, vecs[i].r2);
      wb(vecs[i].we, vecs[i].wrd, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_pc", i),    out_pc, vecs[i].pc);
      check($sformatf("v%0d_rs1", i),   out_rs1_val, vecs[i].e_rs1);
      check($sformatf("v%0d_rs2", i),   out_rs2_val, vecs[i].e_rs2);
      check($sformatf("v%0d_imm", i),   out_imm, vecs[i].e_imm);
      check($sformatf("v%0d_rd", i),    32'(out_rd), 32'(vecs[i].e_rd));
      check($sformatf("v%0d_op", i),    32'(out_opcode), 32'(vecs[i].e_op));
      check($sformatf("v%0d_f3", i),    32'(out_funct3), 32'(vecs[i].e_f3));
      check($sformatf("v%0d_f7", i),    32'(out_funct7), 32'(vecs[i].e_f7));
      check($sformatf("v%0d_ctl", i),   32'({out_reg_write, out_mem_read, out_mem_write}),
            32'({vecs[i].e_rw, vecs[i].e_mr, vecs[i].e_mw}));
    end

    // Drain the load so it cannot stall the next sequence.
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: hold ADD x10,x3,x9 for three cycles, x9 written back in the second.
    drive(1'b1, 32'h00918533, 32'h200, 32'h11, 32'h99);
    @(negedge clk);
    check("bp_load_rs2", out_rs2_val, 32'h99);
    out_ready = 1'b0;
    drive(1'b1, 32'hFFD00293, 32'h204, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("bp%0d_in_ready", i), 32'(in_ready), 32'd0);
      wb(i == 1, 5'd9, 32'h55);
      @(negedge clk);
      check($sformatf("bp%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d_pc", i),    out_pc, 32'h200);
      check($sformatf("bp%0d_rd", i),    32'(out_rd), 32'd10);
      check($sformatf("bp%0d_rs1", i),   out_rs1_val, 32'h11);
      check($sformatf("bp%0d_rs2", i),   out_rs2_val, (i >= 1) ? 32'h55 : 32'h99);
    end
    wb(1'b0, 5'd0, 32'h0);

    // Release with a new instruction waiting: replaced without a bubble.
    out_ready = 1'b1;
    #1;
    check("replace_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("replace_valid", 32'(out_valid), 32'd1);
    check("replace_pc", out_pc, 32'h204);
    check("replace_imm", out_imm, 32'hFFFFFFFD);

    // Load-use: LW x3,0(x2) then ADD x4,x3,x1.
    drive(1'b1, 32'h00012183, 32'h300, 32'h2000, 32'h0);
    @(negedge clk);
    check("lu_load_mr", 32'({out_valid, out_mem_read}), 32'b11);
    drive(1'b1, 32'h00118233, 32'h304, 32'h30, 32'h31);
    #1;
`ifdef LOAD_USE_STALL_EN
    check("lu_stall_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("lu_bubble_valid", 32'(out_valid), 32'd0);
    #1;
    check("lu_resume_ready", 32'(in_ready), 32'd1);
`else
    check("lu_nostall_ready", 32'(in_ready), 32'd1);
`endif
    @(negedge clk);
    check("lu_add_valid", 32'(out_valid), 32'd1);
    check("lu_add_pc", out_pc, 32'h304);
    check("lu_add_rs1", out_rs1_val, 32'h30);

    // Flush while a load is held and its dependent is presented.
    drive(1'b1, 32'h00012183, 32'h400, 32'h2000, 32'h0);
    @(negedge clk);
    check("fl_load_pc", out_pc, 32'h400);
    drive(1'b1, 32'h00118233, 32'h404, 32'h30, 32'h31);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_not_captured", 32'(out_pc != 32'h404), 32'd1);
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    check("fl_retry_valid", 32'(out_valid), 32'd1);
    check("fl_retry_pc", out_pc, 32'h404);

    // Reset while stalled behind a held bundle.
    out_ready = 1'b0;
    drive(1'b1, 32'hFFD00293, 32'h500, 32'h0, 32'h0);
    #1;
    check("rs_stall_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rs_mid");
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    #1;
    check("rs_in_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
